rock_level_ctrl: RTL and testbench

ROCK_LEVEL_CTRL -- requirements
Module: rock_level_ctrl

---
 rtl/rock_level_ctrl.sv | 81 ++++++++
 tb/tb_rock_level_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rock_level_ctrl.sv
// rock_level_ctrl: saturating frequency/amplitude level controller with idle auto-decay and stop detection
// Ports: clk, reset (async, active-high); tick (slow-time enable); f_up/f_down, a_up/a_down (level requests);
//        f, a (registered levels); f_zero, af_zero (zero flags); state (0 RUN, 1 DECAY, 2 STOP);
//        sat (one-cycle pulse after a blocked lone request).
// Build option: define ROCK_LEVEL_AUTO_DECAY_EN to include the idle counter, DECAY state and auto-decrement.
module rock_level_ctrl #(
  parameter int W         = 3,
  parameter int F_INIT    = 5,
  parameter int A_INIT    = 5,
  parameter int F_MAX     = 7,
  parameter int A_MAX     = 7,
  parameter int DECAY_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         f_up,
  input  logic         f_down,
  input  logic         a_up,
  input  logic         a_down,
  output logic [W-1:0] f,
  output logic [W-1:0] a,
  output logic         f_zero,
  output logic         af_zero,
  output logic [1:0]   state,
  output logic         sat
);
  typedef enum logic [1:0] {RUN = 2'd0, DECAY = 2'd1, STOP = 2'd2} state_t;
  localparam state_t ST_INIT = (F_INIT == 0 && A_INIT == 0) ? STOP : RUN;
  state_t st, st_n;
  logic [W-1:0] f_n, a_n;
  logic f_inc, f_dec, a_inc, a_dec, f_hi, f_lo, a_hi, a_lo, act, blk, decay, go_decay;
  assign state   = st;
  assign f_zero  = f == '0;
  assign af_zero = f_zero && a == '0;
  // Opposing requests on the same register cancel and are never treated as blocked.
  assign f_inc = f_up & ~f_down;
  assign f_dec = f_down & ~f_up;
  assign a_inc = a_up & ~a_down;
  assign a_dec = a_down & ~a_up;
  assign f_hi  = f == W'(F_MAX);
  assign f_lo  = f == '0;
  assign a_hi  = a == W'(A_MAX);
  assign a_lo  = a == '0;
  assign act   = f_up | f_down | a_up | a_down;
  assign blk   = (f_inc & f_hi) | (f_dec & f_lo) | (a_inc & a_hi) | (a_dec & a_lo);
`ifdef ROCK_LEVEL_AUTO_DECAY_EN
  localparam int CW = $clog2(DECAY_DIV + 1);
  logic [CW-1:0] cnt, cnt_n;
  // Decay only ever runs on idle ticks, so any user request suppresses it that cycle.
  assign decay    = st == DECAY && tick && !act;
  assign go_decay = st == RUN && tick && !act && cnt == CW'(DECAY_DIV - 1);
  assign cnt_n    = act ? '0 : (tick && cnt != CW'(DECAY_DIV)) ? cnt + 1'b1 : cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= cnt_n;
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign decay       = 1'b0;
  assign go_decay    = 1'b0;
`endif
  always_comb begin
    f_n  = (f_inc && !f_hi) ? f + 1'b1 : (f_dec && !f_lo) ? f - 1'b1 : f;
    a_n  = (a_inc && !a_hi) ? a + 1'b1 : (a_dec && !a_lo) ? a - 1'b1 : (decay && !a_lo) ? a - 1'b1 : a;
    // Reaching zero on both levels wins over every other transition; in STOP only an up request escapes.
    st_n = (f_n == '0 && a_n == '0) ? STOP : act ? RUN : go_decay ? DECAY : st;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      f   <= W'(F_INIT);
      a   <= W'(A_INIT);
      st  <= ST_INIT;
      sat <= 1'b0;
    end else begin
      f   <= f_n;
      a   <= a_n;
      st  <= st_n;
      sat <= blk;
    end
endmodule

// File: tb/tb_rock_level_ctrl.sv
// tb_rock_level_ctrl: table-driven and directed-sequence checker for rock_level_ctrl (default parameters)
module tb_rock_level_ctrl;
  logic clk = 0, reset = 1, tick = 0, f_up = 0, f_down = 0, a_up = 0, a_down = 0;
  logic [2:0] f, a;
  logic f_zero, af_zero, sat;
  logic [1:0] state;
  int nvec = 0, nfail = 0;

  rock_level_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .f_up(f_up), .f_down(f_down),
    .a_up(a_up), .a_down(a_down), .f(f), .a(a), .f_zero(f_zero),
    .af_zero(af_zero), .state(state), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] in;
    logic [2:0] ef;
    logic [2:0] ea;
    logic [1:0] es;
    logic       esat;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [4:0] in, input logic [2:0] ef, input logic [2:0] ea,
                     input logic [1:0] es, input logic esat);
    vec_t v;
    v.in = in; v.ef = ef; v.ea = ea; v.es = es; v.esat = esat;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] ef, input logic [2:0] ea,
                       input logic [1:0] es, input logic esat);
    logic efz, eafz;
    efz  = ef == 3'd0;
    eafz = efz && ea == 3'd0;
    nvec++;
    if (f !== ef || a !== ea || state !== es || sat !== esat || f_zero !== efz || af_zero !== eafz) begin
      nfail++;
      $display("FAIL %s: got f=%0d a=%0d state=%0d sat=%0b fz=%0b afz=%0b, want f=%0d a=%0d state=%0d sat=%0b fz=%0b afz=%0b",
               name, f, a, state, sat, f_zero, af_zero, ef, ea, es, esat, efz, eafz);
    end
  endtask

  task automatic step(input logic [4:0] in);
    {tick, f_up, f_down, a_up, a_down} = in;
    @(posedge clk); #1;
    {tick, f_up, f_down, a_up, a_down} = 5'b0;
  endtask

  task automatic do_reset;
    {tick, f_up, f_down, a_up, a_down} = 5'b0;
    reset = 1; #13; reset = 0; #1;
  endtask

  task automatic idle_tick;
    step(5'b10000);
    step(5'b00000);
  endtask

  initial begin
    // inputs {tick,f_up,f_down,a_up,a_down} -> expected f, a, state, sat
    add(5'b01000, 3'd6, 3'd5, 2'd0, 1'b0);
    add(5'b01000, 3'd7, 3'd5, 2'd0, 1'b0);
    add(5'b01000, 3'd7, 3'd5, 2'd0, 1'b1);
    add(5'b01000, 3'd7, 3'd5, 2'd0, 1'b1);
    add(5'b01100, 3'd7, 3'd5, 2'd0, 1'b0);
    add(5'b11100, 3'd7, 3'd5, 2'd0, 1'b0);
    add(5'b01100, 3'd7, 3'd5, 2'd0, 1'b0);
    add(5'b00000, 3'd7, 3'd5, 2'd0, 1'b0);
    add(5'b00010, 3'd7, 3'd6, 2'd0, 1'b0);
    add(5'b00010, 3'd7, 3'd7, 2'd0, 1'b0);
    add(5'b00010, 3'd7, 3'd7, 2'd0, 1'b1);
    add(5'b00011, 3'd7, 3'd7, 2'd0, 1'b0);
    add(5'b10001, 3'd7, 3'd6, 2'd0, 1'b0);
    add(5'b00100, 3'd6, 3'd6, 2'd0, 1'b0);
    add(5'b00110, 3'd5, 3'd7, 2'd0, 1'b0);
    add(5'b00110, 3'd4, 3'd7, 2'd0, 1'b1);
    add(5'b00101, 3'd3, 3'd6, 2'd0, 1'b0);
    add(5'b00101, 3'd2, 3'd5, 2'd0, 1'b0);
    add(5'b00101, 3'd1, 3'd4, 2'd0, 1'b0);
    add(5'b00101, 3'd0, 3'd3, 2'd0, 1'b0);
    add(5'b00101, 3'd0, 3'd2, 2'd0, 1'b1);
    add(5'b00001, 3'd0, 3'd1, 2'd0, 1'b0);
    add(5'b00001, 3'd0, 3'd0, 2'd2, 1'b0);
    add(5'b00001, 3'd0, 3'd0, 2'd2, 1'b1);
    add(5'b00100, 3'd0, 3'd0, 2'd2, 1'b1);
    add(5'b01100, 3'd0, 3'd0, 2'd2, 1'b0);
    add(5'b00010, 3'd0, 3'd1, 2'd0, 1'b0);
    add(5'b00001, 3'd0, 3'd0, 2'd2, 1'b0);
    add(5'b01000, 3'd1, 3'd0, 2'd0, 1'b0);
    add(5'b00100, 3'd0, 3'd0, 2'd2, 1'b0);

    do_reset;
    check("reset_defaults", 3'd5, 3'd5, 2'd0, 1'b0);
    foreach (vq[i]) begin
      step(vq[i].in);
      check($sformatf("vec%0d", i), vq[i].ef, vq[i].ea, vq[i].es, vq[i].esat);
    end

    // asynchronous reset from STOP, observed before any clock edge
    @(negedge clk);
    reset = 1; #1;
    check("async_reset_from_stop", 3'd5, 3'd5, 2'd0, 1'b0);
    @(posedge clk); #1; reset = 0;

`ifdef ROCK_LEVEL_AUTO_DECAY_EN
    do_reset;
    for (int i = 0; i < 5; i++) step(5'b00100);
    check("f_to_zero", 3'd0, 3'd5, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle_tick;
    check("idle_3_ticks_run", 3'd0, 3'd5, 2'd0, 1'b0);
    idle_tick;
    check("enter_decay", 3'd0, 3'd5, 2'd1, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      idle_tick;
      check($sformatf("decay_a%0d", i), 3'd0, 3'(i), 2'd1, 1'b0);
    end
    idle_tick;
    check("decay_to_stop", 3'd0, 3'd0, 2'd2, 1'b0);

    do_reset;
    for (int i = 0; i < 4; i++) idle_tick;
    check("decay_entry2", 3'd5, 3'd5, 2'd1, 1'b0);
    idle_tick;
    idle_tick;
    check("decay_a3", 3'd5, 3'd3, 2'd1, 1'b0);
    step(5'b10001);
    check("adown_with_tick", 3'd5, 3'd2, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle_tick;
    check("counter_cleared", 3'd5, 3'd2, 2'd0, 1'b0);
    idle_tick;
    check("redecay_after_4", 3'd5, 3'd2, 2'd1, 1'b0);
    // reset in DECAY aborts with no further step
    tick = 1;
    @(negedge clk);
    reset = 1; #1;
    check("async_reset_in_decay", 3'd5, 3'd5, 2'd0, 1'b0);
    @(posedge clk); #1;
    check("reset_held_in_decay", 3'd5, 3'd5, 2'd0, 1'b0);
    tick = 0; reset = 0;
`else
    do_reset;
    for (int i = 0; i < 10; i++) idle_tick;
    check("no_decay_without_macro", 3'd5, 3'd5, 2'd0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
